// File: rtl/cpu_pkg.sv
// Shared constants, types and helpers for the note CPU fetch front-end.
package cpu_pkg;
  localparam int ADDR_W    = 10;
  localparam int PC_W      = 64;
  localparam int INS_BYTES = 4;
  localparam int NOTE_LSB  = 23;
  localparam int NOTE_W    = 8;
  localparam int INS_W     = 8 * INS_BYTES;

  typedef logic [INS_W-1:0] ins_t;
  typedef logic [PC_W-1:0]  pc_t;

  typedef enum logic {ST_FETCH, ST_HOLD} fetch_state_e;

  function automatic logic is_single_note(ins_t ins);
    return ins[NOTE_LSB +: NOTE_W] == '0;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Push/pop/flush handshake between the fetch assembler and its instruction queue.
interface fetch_unit_if #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  modport master (output push, pop, flush, wdata, input rdata, full, empty, count);
  modport slave  (input push, pop, flush, wdata, output rdata, full, empty, count);
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with occupancy counter and synchronous flush; push while
// full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  f
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign f.empty  = (count_q == '0);
  assign f.full   = (count_q == CW'(DEPTH));
  assign f.count  = count_q;
  assign f.rdata  = mem_q[head_q];
  assign do_pop   = f.pop & ~f.empty;
  assign do_push  = f.push & (~f.full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !rst && !f.flush) mem_q[tail_q] <= f.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || f.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles INS_BYTES-byte words from a
// combinational byte memory and queues {pc, ins} for decode.
module fetch_unit #(
  parameter int ADDR_W     = cpu_pkg::ADDR_W,
  parameter int PC_W       = cpu_pkg::PC_W,
  parameter int INS_BYTES  = cpu_pkg::INS_BYTES,
  parameter int DEPTH      = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int NOTE_LSB   = cpu_pkg::NOTE_LSB,
  parameter int NOTE_W     = cpu_pkg::NOTE_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clkOut,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [ADDR_W-1:0]          raddr,
  output logic                       mem_en,
  input  logic [7:0]                 rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*INS_BYTES-1:0]     out_ins,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_single_note,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import cpu_pkg::*;

  localparam int INS_W = 8 * INS_BYTES;
  localparam int KW    = (INS_BYTES > 1) ? $clog2(INS_BYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(INS_BYTES - 1);

  fetch_state_e      state_q;
  logic [PC_W-1:0]   pc_q;
  logic [KW-1:0]     k_q;
  logic [INS_W-1:0]  asm_q;
  logic [INS_W-1:0]  asm_byte;
  logic [KW-1:0]     slot;
  logic              at_last, pop, stall;

  fetch_unit_if #(.WIDTH(PC_W + INS_W), .DEPTH(DEPTH)) fq ();

  sync_fifo #(.WIDTH(PC_W + INS_W), .DEPTH(DEPTH)) u_queue (
    .clk (clkOut),
    .rst (reset),
    .f   (fq.slave)
  );

  // HOLD only ever parks on the last byte, so it also marks the last slot.
  assign at_last = (state_q == ST_HOLD) | (k_q == KLAST);
  assign pop     = out_valid & out_ready;
  assign stall   = at_last & fq.full & ~pop;
  assign mem_en  = fetch_en & ~reset & ~redirect_valid & ~stall;
  assign raddr   = pc_q[ADDR_W-1:0] + ADDR_W'(k_q);
  assign slot    = (BIG_ENDIAN != 0) ? (KLAST - k_q) : k_q;

  always_comb begin
    asm_byte = asm_q;
    asm_byte[slot*8 +: 8] = rdata;
  end

  assign fq.push  = mem_en & at_last;
  assign fq.wdata = {pc_q, asm_byte};
  assign fq.pop   = pop;
  assign fq.flush = redirect_valid;

  assign out_valid       = ~fq.empty & ~reset;
  assign {out_pc, out_ins} = fq.rdata;
  assign out_single_note = out_valid & (out_ins[NOTE_LSB +: NOTE_W] == '0);
  assign count           = fq.count;

  always_ff @(posedge clkOut) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      k_q     <= '0;
      asm_q   <= '0;
    end else if (redirect_valid) begin
      state_q <= ST_FETCH;
      pc_q    <= redirect_pc;
      k_q     <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= stall ? ST_HOLD : ST_FETCH;
      if (mem_en) begin
        if (at_last) begin
          k_q   <= '0;
          asm_q <= '0;
          pc_q  <= pc_q + PC_W'(INS_BYTES);
        end else begin
          k_q   <= k_q + 1'b1;
          asm_q <= asm_byte;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized run against a transaction-level fetch model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [9:0]  raddr;
  logic        mem_en;
  logic [7:0]  rdata;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [63:0] out_pc;
  logic        out_single_note;
  logic [2:0]  count;

  logic [9:0]  be_raddr;
  logic        be_mem_en, be_valid, be_sn;
  logic [7:0]  be_rdata;
  logic [31:0] be_ins;
  logic [63:0] be_pc;
  logic [2:0]  be_count;
  logic        be_ready = 1'b1;
  logic        be_redir = 1'b0;
  logic [63:0] be_rpc = '0;

  logic [7:0] mem    [1024];
  logic [7:0] mem_be [1024];
  assign rdata    = mem[raddr];
  assign be_rdata = mem_be[be_raddr];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clkOut(clk), .reset(rst), .fetch_en(fetch_en), .raddr(raddr), .mem_en(mem_en),
    .rdata(rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .out_single_note(out_single_note), .count(count)
  );

  fetch_unit #(.BIG_ENDIAN(1)) dut_be (
    .clkOut(clk), .reset(rst), .fetch_en(fetch_en), .raddr(be_raddr), .mem_en(be_mem_en),
    .rdata(be_rdata), .redirect_valid(be_redir), .redirect_pc(be_rpc),
    .out_valid(be_valid), .out_ready(be_ready), .out_ins(be_ins), .out_pc(be_pc),
    .out_single_note(be_sn), .count(be_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Little-endian instruction at pc, byte addresses wrap at 1 KiB.
  function automatic logic [31:0] ins_at(input logic [63:0] pc);
    logic [31:0] r;
    logic [9:0]  a;
    for (int i = 0; i < 4; i++) begin
      a = pc[9:0] + 10'(i);
      r[8*i +: 8] = mem[a];
    end
    return r;
  endfunction

  function automatic logic note_zero(input logic [31:0] ins);
    return ins[30:23] == 8'h00;
  endfunction

  // Leaves the caller at the negedge of cycle 0 with reset released.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        valid;
    int          cnt;
    logic [9:0]  raddr;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        sn;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n;
    logic [63:0] exp_pc;
    logic [31:0] e;

    tbl[0] = '{1'b1, 1'b0, 0, 10'd0, 64'd0, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 0, 10'd1, 64'd0, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 0, 10'd2, 64'd0, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 0, 10'd3, 64'd0, 32'h0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1, 10'd4, 64'd0, 32'h12345678, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 0, 10'd5, 64'd0, 32'h0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 0, 10'd6, 64'd0, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 0, 10'd7, 64'd0, 32'h0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1, 10'd8, 64'd4, 32'h80000005, 1'b1};

    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      mem_be[i] = 8'h00;
    end
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    mem[4] = 8'h05; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h80;
    mem[10'h3FE] = 8'hAA; mem[10'h3FF] = 8'hBB;
    mem_be[0] = 8'h12; mem_be[1] = 8'h34; mem_be[2] = 8'h56; mem_be[3] = 8'h78;

    // Directed streaming table from reset.
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      fetch_en = 1'b1;
      out_ready = tbl[c].ready;
      #1;
      chk($sformatf("tbl%0d_valid", c), out_valid, tbl[c].valid);
      chk($sformatf("tbl%0d_count", c), count, tbl[c].cnt);
      chk($sformatf("tbl%0d_raddr", c), raddr, tbl[c].raddr);
      chk($sformatf("tbl%0d_mem_en", c), mem_en, 1);
      chk($sformatf("tbl%0d_sn", c), out_single_note, tbl[c].sn);
      if (tbl[c].valid) begin
        chk($sformatf("tbl%0d_pc", c), out_pc, tbl[c].pc);
        chk($sformatf("tbl%0d_ins", c), out_ins, tbl[c].ins);
      end
      if (c == 4) begin
        chk("be_valid", be_valid, 1);
        chk("be_ins", be_ins, 32'h12345678);
      end
    end

    // Backpressure: fill, stall on fifth last byte, then drain in order.
    reset_dut();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      fetch_en = 1'b1; out_ready = 1'b0;
      #1;
      if (c == 16) chk("bp_count_full", count, 4);
      if (c == 18) chk("bp_mem_en_c18", mem_en, 1);
      if (c == 19) begin
        chk("bp_mem_en_stall", mem_en, 0);
        chk("bp_raddr_stall", raddr, 19);
      end
      if (c == 39) begin
        chk("bp_count_held", count, 4);
        chk("bp_mem_en_held", mem_en, 0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_push_pop_full", mem_en, 1);
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (out_valid) begin
        chk($sformatf("bp_pc%0d", n), out_pc, 64'(4 * n));
        chk($sformatf("bp_ins%0d", n), out_ins, ins_at(64'(4 * n)));
        n++;
      end
    end
    chk("bp_delivered", n, 5);

    // Reset while parked in HOLD with a full queue.
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clk);
      fetch_en = 1'b1; out_ready = 1'b0;
      #1;
    end
    chk("hold_mem_en", mem_en, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rsthold_mem_en", mem_en, 0);
    chk("rsthold_valid_during", out_valid, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rsthold_valid", out_valid, 0);
    chk("rsthold_count", count, 0);
    chk("rsthold_raddr", raddr, 0);
    chk("rsthold_mem_en", mem_en, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("rsthold_refetch_valid", out_valid, 1);
    chk("rsthold_refetch_pc", out_pc, 0);

    // Redirect at k=2 with two entries queued, landing across the address wrap.
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      fetch_en = 1'b1; out_ready = 1'b0;
      #1;
      if (c == 8) chk("rd_count2", count, 2);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h3FE;
    #1;
    chk("rd_raddr_k2", raddr, 10);
    chk("rd_mem_en_off", mem_en, 0);
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rd_count0", count, 0);
    chk("rd_valid0", out_valid, 0);
    chk("rd_raddr0", raddr, 10'h3FE);
    @(negedge clk); #1; chk("rd_raddr1", raddr, 10'h3FF);
    @(negedge clk); #1; chk("rd_raddr2", raddr, 10'h000);
    @(negedge clk); #1; chk("rd_raddr3", raddr, 10'h001);
    @(negedge clk); #1;
    chk("rd_valid", out_valid, 1);
    chk("rd_pc", out_pc, 64'h3FE);
    chk("rd_ins", out_ins, 32'h5678BBAA);

    // Randomized run against the sequential-PC stream model.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    reset_dut();
    exp_pc = 64'd0;
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      fetch_en       = ($urandom_range(9) < 8);
      out_ready      = ($urandom_range(9) < 6);
      redirect_valid = ($urandom_range(31) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? 64'(1024 - $urandom_range(1, 6))
                                                : {$urandom, $urandom};
      #1;
      chk("rnd_valid_vs_count", out_valid, (count != 0));
      chk("rnd_mem_en_gate", mem_en & ~(fetch_en & ~redirect_valid), 0);
      if (count > 4) chk("rnd_count_bound", count, 4);
      if (out_valid && out_ready) begin
        e = ins_at(exp_pc);
        chk("rnd_pc", out_pc, exp_pc);
        chk("rnd_ins", out_ins, e);
        chk("rnd_sn", out_single_note, note_zero(e));
        exp_pc = exp_pc + 64'd4;
        n++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    chk("rnd_progress", (n > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
